// File: rtl/jt10_adpcm_mch_if.sv
// Sample bus between the host and the multichannel ADPCM-A decoder.
// The master supplies nibbles and channel controls; the slave returns PCM and the frame mix.
interface jt10_adpcm_mch_if #(
  parameter int unsigned CH = 6
);
  logic [2:0]    slot;
  logic [3:0]    data;
  logic [CH-1:0] chon;
  logic [CH-1:0] clr;
  logic [15:0]   pcm;
  logic [2:0]    pcm_ch;
  logic          pcm_valid;
  logic [18:0]   mix;
  logic          mix_valid;

  modport master (
    input  slot, pcm, pcm_ch, pcm_valid, mix, mix_valid,
    output data, chon, clr
  );

  modport slave (
    output slot, pcm, pcm_ch, pcm_valid, mix, mix_valid,
    input  data, chon, clr
  );
endinterface

// File: rtl/jt10_adpcm_mch.sv
// Time-multiplexed ADPCM-A decoder: CH channels share one 4-stage pipeline plus a frame mixer.
// Define JT10_ADPCM_SAT_EN to saturate the accumulator; by default it wraps modulo 2^SIGW.

module jt10_adpcma_lut (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [8:0]  addr,
  output logic [11:0] inc
);
  logic [10:0] step_size;
  logic [14:0] prod;

  always_comb begin
    case (addr[8:3])
      6'd0:  step_size = 11'd16;   6'd1:  step_size = 11'd17;   6'd2:  step_size = 11'd19;
      6'd3:  step_size = 11'd21;   6'd4:  step_size = 11'd23;   6'd5:  step_size = 11'd25;
      6'd6:  step_size = 11'd28;   6'd7:  step_size = 11'd31;   6'd8:  step_size = 11'd34;
      6'd9:  step_size = 11'd37;   6'd10: step_size = 11'd41;   6'd11: step_size = 11'd45;
      6'd12: step_size = 11'd50;   6'd13: step_size = 11'd55;   6'd14: step_size = 11'd60;
      6'd15: step_size = 11'd66;   6'd16: step_size = 11'd73;   6'd17: step_size = 11'd80;
      6'd18: step_size = 11'd88;   6'd19: step_size = 11'd97;   6'd20: step_size = 11'd107;
      6'd21: step_size = 11'd118;  6'd22: step_size = 11'd130;  6'd23: step_size = 11'd143;
      6'd24: step_size = 11'd157;  6'd25: step_size = 11'd173;  6'd26: step_size = 11'd190;
      6'd27: step_size = 11'd209;  6'd28: step_size = 11'd230;  6'd29: step_size = 11'd253;
      6'd30: step_size = 11'd279;  6'd31: step_size = 11'd307;  6'd32: step_size = 11'd337;
      6'd33: step_size = 11'd371;  6'd34: step_size = 11'd408;  6'd35: step_size = 11'd449;
      6'd36: step_size = 11'd494;  6'd37: step_size = 11'd544;  6'd38: step_size = 11'd598;
      6'd39: step_size = 11'd658;  6'd40: step_size = 11'd724;  6'd41: step_size = 11'd796;
      6'd42: step_size = 11'd876;  6'd43: step_size = 11'd963;  6'd44: step_size = 11'd1060;
      6'd45: step_size = 11'd1166; 6'd46: step_size = 11'd1282; 6'd47: step_size = 11'd1411;
      6'd48: step_size = 11'd1552;
      default: step_size = 11'd0;
    endcase
  end

  // inc = (2*mag + 1) * step / 8
  assign prod = 15'(step_size) * 15'({addr[2:0], 1'b1});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inc <= '0;
    end else if (cen) begin
      inc <= 12'(prod >> 3);
    end
  end
endmodule

module jt10_adpcm_mch #(
  parameter int unsigned CH   = 6,
  parameter int unsigned SIGW = 12
) (
  input logic             clk,
  input logic             rst,
  input logic             cen,
  jt10_adpcm_mch_if.slave bus
);
  localparam logic [2:0] LAST = 3'(CH - 1);

  logic [2:0]             slot_q;
  logic [5:0]             step_q [8];
  logic signed [SIGW-1:0] x_q [8];
  logic [7:0]             chon_all, clr_all;
  logic [5:0]             step_cur, step_nxt;
  logic [6:0]             step_add;

  logic                   v1_q, v2_q, v3_q;
  logic [2:0]             k1_q, k2_q, k3_q;
  logic                   sign1_q, sign2_q;
  logic                   chon1_q, chon2_q, chon3_q;
  logic                   clr1_q, clr2_q, clr3_q;
  logic [8:0]             addr_q;
  logic [11:0]            inc;
  logic [SIGW:0]          inc_ext;
  // One bit wider than SIGW so a full 12-bit magnitude keeps its sign for saturation
  logic signed [SIGW:0]   incs_q;
  logic signed [SIGW-1:0] x_cur, x_new, x_upd;
  logic signed [SIGW+1:0] sum;
  logic signed [18:0]     acc_q, acc_sum, mix_q;
  logic [15:0]            pcm_q;
  logic [2:0]             pcm_ch_q;
  logic                   pcm_valid_q, mix_valid_q;

  assign chon_all = 8'(bus.chon);
  assign clr_all  = 8'(bus.clr);
  assign step_cur = step_q[slot_q];

  always_comb begin
    step_add = {1'b0, step_cur};
    if (!bus.data[2]) begin
      step_add = (step_cur == 6'd0) ? 7'd0 : {1'b0, step_cur} - 7'd1;
    end else begin
      case (bus.data[1:0])
        2'd0:    step_add = {1'b0, step_cur} + 7'd2;
        2'd1:    step_add = {1'b0, step_cur} + 7'd5;
        2'd2:    step_add = {1'b0, step_cur} + 7'd7;
        default: step_add = {1'b0, step_cur} + 7'd9;
      endcase
    end
    step_nxt = (step_add > 7'd48) ? 6'd48 : step_add[5:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '0;
      v1_q    <= 1'b0;
      k1_q    <= '0;
      sign1_q <= 1'b0;
      chon1_q <= 1'b0;
      clr1_q  <= 1'b0;
      addr_q  <= '0;
      for (int i = 0; i < 8; i++) step_q[i] <= '0;
    end else if (cen) begin
      slot_q  <= (slot_q == LAST) ? 3'd0 : slot_q + 3'd1;
      v1_q    <= 1'b1;
      k1_q    <= slot_q;
      sign1_q <= bus.data[3];
      chon1_q <= chon_all[slot_q];
      clr1_q  <= clr_all[slot_q];
      addr_q  <= {step_cur, bus.data[2:0]};
      if (clr_all[slot_q]) begin
        step_q[slot_q] <= '0;
      end else if (chon_all[slot_q]) begin
        step_q[slot_q] <= step_nxt;
      end
    end
  end

  jt10_adpcma_lut u_lut (
    .clk   (clk),
    .rst_n (~rst),
    .cen   (cen),
    .addr  (addr_q),
    .inc   (inc)
  );

  assign inc_ext = {{(SIGW - 11){1'b0}}, inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q    <= 1'b0;
      k2_q    <= '0;
      sign2_q <= 1'b0;
      chon2_q <= 1'b0;
      clr2_q  <= 1'b0;
      v3_q    <= 1'b0;
      k3_q    <= '0;
      chon3_q <= 1'b0;
      clr3_q  <= 1'b0;
      incs_q  <= '0;
    end else if (cen) begin
      v2_q    <= v1_q;
      k2_q    <= k1_q;
      sign2_q <= sign1_q;
      chon2_q <= chon1_q;
      clr2_q  <= clr1_q;
      v3_q    <= v2_q;
      k3_q    <= k2_q;
      chon3_q <= chon2_q;
      clr3_q  <= clr2_q;
      incs_q  <= sign2_q ? -inc_ext : inc_ext;
    end
  end

  assign x_cur = x_q[k3_q];
  assign sum   = (SIGW + 2)'(x_cur) + (SIGW + 2)'(incs_q);

`ifdef JT10_ADPCM_SAT_EN
  always_comb begin
    if (sum[SIGW+1:SIGW-1] == 3'b000 || sum[SIGW+1:SIGW-1] == 3'b111) begin
      x_new = sum[SIGW-1:0];
    end else begin
      x_new = sum[SIGW+1] ? {1'b1, {(SIGW - 1){1'b0}}} : {1'b0, {(SIGW - 1){1'b1}}};
    end
  end
`else
  logic [1:0] unused_sum_hi;
  assign unused_sum_hi = sum[SIGW+1:SIGW];
  assign x_new         = sum[SIGW-1:0];
`endif

  assign x_upd   = clr3_q ? '0 : (chon3_q ? x_new : x_cur);
  assign acc_sum = acc_q + 19'(x_upd);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) x_q[i] <= '0;
      pcm_q       <= '0;
      pcm_ch_q    <= '0;
      pcm_valid_q <= 1'b0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      acc_q       <= '0;
    end else if (cen) begin
      pcm_valid_q <= v3_q;
      mix_valid_q <= 1'b0;
      if (v3_q) begin
        x_q[k3_q] <= x_upd;
        pcm_q     <= 16'(x_upd);
        pcm_ch_q  <= k3_q;
        if (k3_q == LAST) begin
          mix_q       <= acc_sum;
          mix_valid_q <= 1'b1;
          acc_q       <= '0;
        end else begin
          acc_q <= acc_sum;
        end
      end
    end else begin
      pcm_valid_q <= 1'b0;
      mix_valid_q <= 1'b0;
    end
  end

  assign bus.slot      = slot_q;
  assign bus.pcm       = pcm_q;
  assign bus.pcm_ch    = pcm_ch_q;
  assign bus.pcm_valid = pcm_valid_q;
  assign bus.mix       = mix_q;
  assign bus.mix_valid = mix_valid_q;
endmodule
